// File: rtl/lns_stream_proc.sv
// lns_stream_proc: host-bus LNS arithmetic unit (MUL/DIV/SQR/SQRT) with a
// fixed-latency pipeline, result FIFO and sticky status flags.
module lns_stream_proc #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int PIPE_DEPTH = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic             dataORstatus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = WIDTH - 2;
  localparam int IW = WIDTH - 1;
  localparam int NS = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 1;
  localparam logic signed [IW-1:0] LMAX = IW'((1 << (WIDTH - 3)) - 1);
  localparam logic signed [IW-1:0] LMIN = IW'(-(1 << (WIDTH - 3)));

  typedef enum logic [1:0] {M_MUL, M_DIV, M_SQR, M_SQRT} mode_e;

  if (FRAC >= LW) begin : g_frac_too_wide
    logic frac_exceeds_log_field;
  end

  mode_e            mode_q, mode_d;
  logic             prev_w_q, prev_w_d;
  logic             prev_r_q, prev_r_d;
  logic             a_pend_q, a_pend_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             nan_q, nan_d;
  logic             drp_q, drp_d;
  logic [NS-1:0]    pv_q, pv_d;
  logic [WIDTH-1:0] pr_q [NS];
  logic [WIDTH-1:0] pr_d [NS];
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic wstb, rstb, ctl_wr, dat_wr, dat_rd, flush;

  assign wstb   = cs & wr & ~prev_w_q;
  assign rstb   = cs & rd & ~prev_r_q;
  assign ctl_wr = wstb & dataORstatus;
  assign dat_wr = wstb & ~dataORstatus;
  assign dat_rd = rstb & ~dataORstatus;
  assign flush  = ctl_wr & din[3];
  assign dout   = dout_q;

  logic [WIDTH-1:0]     op_a, op_b, res;
  logic signed [IW-1:0] la, lb, lsum;
  logic                 sa, sb, za, zb;
  logic                 sgn, zres, sat;
  logic                 ovf_c, unf_c, nan_c;

  always_comb begin
    op_a  = mode_q[1] ? din : a_q;
    op_b  = din;
    sa    = op_a[WIDTH-1];
    sb    = op_b[WIDTH-1];
    za    = op_a[WIDTH-2];
    zb    = op_b[WIDTH-2];
    la    = {op_a[LW-1], op_a[LW-1:0]};
    lb    = {op_b[LW-1], op_b[LW-1:0]};
    lsum  = '0;
    sgn   = 1'b0;
    zres  = 1'b0;
    sat   = 1'b0;
    nan_c = 1'b0;
    unf_c = 1'b0;
    unique case (mode_q)
      M_MUL: begin
        if (za | zb) zres = 1'b1;
        else begin
          sgn  = sa ^ sb;
          lsum = la + lb;
        end
      end
      M_DIV: begin
        if (zb) begin
          sgn = sa ^ sb;
          sat = 1'b1;
        end else if (za) zres = 1'b1;
        else begin
          sgn  = sa ^ sb;
          lsum = la - lb;
        end
      end
      M_SQR: begin
        if (za) zres = 1'b1;
        else lsum = la + la;
      end
      M_SQRT: begin
        if (za) zres = 1'b1;
        else if (sa) begin
          zres  = 1'b1;
          nan_c = 1'b1;
        end else lsum = la >>> 1;
      end
    endcase
    if (!zres && !sat) begin
      if (lsum > LMAX) sat = 1'b1;
      else if (lsum < LMIN) begin
        zres  = 1'b1;
        unf_c = 1'b1;
      end
    end
    ovf_c = sat;
    if (zres)     res = {2'b01, {LW{1'b0}}};
    else if (sat) res = {sgn, 1'b0, LMAX[LW-1:0]};
    else          res = {sgn, 1'b0, lsum[LW-1:0]};
  end

  int               inflight;
  logic             room, issue, push, pop, push_v;
  logic [WIDTH-1:0] push_w, status;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < NS; i++)
      inflight = inflight + (pv_q[i] ? 1 : 0);
    room = (int'(count_q) + inflight) < FIFO_DEPTH;

    prev_w_d = cs & wr;
    prev_r_d = cs & rd;
    mode_d   = mode_q;
    a_d      = a_q;
    a_pend_d = a_pend_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    nan_d    = nan_q;
    drp_d    = drp_q;
    issue    = 1'b0;

    if (ctl_wr) begin
      mode_d = mode_e'(din[1:0]);
      if (mode_e'(din[1:0]) != mode_q || din[3])
        a_pend_d = 1'b0;
      if (din[2]) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        nan_d = 1'b0;
        drp_d = 1'b0;
      end
    end

    // First operand of a binary op is latched without consuming FIFO room.
    if (dat_wr) begin
      if (!mode_q[1] && !a_pend_q) begin
        a_d      = din;
        a_pend_d = 1'b1;
      end else if (!room) drp_d = 1'b1;
      else begin
        issue    = 1'b1;
        a_pend_d = 1'b0;
      end
    end

    if (issue) begin
      ovf_d = ovf_d | ovf_c;
      unf_d = unf_d | unf_c;
      nan_d = nan_d | nan_c;
    end

    pv_d    = '0;
    pr_d    = pr_q;
    pv_d[0] = issue & (PIPE_DEPTH > 1);
    pr_d[0] = res;
    for (int i = 1; i < NS; i++) begin
      pv_d[i] = pv_q[i-1];
      pr_d[i] = pr_q[i-1];
    end
    if (flush) pv_d = '0;

    push_v = (PIPE_DEPTH > 1) ? pv_q[NS-1] : issue;
    push_w = (PIPE_DEPTH > 1) ? pr_q[NS-1] : res;
    push   = push_v & ~flush;
    pop    = dat_rd & (count_q != '0);

    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) begin
      mem_d[wp_q] = push_w;
      wp_d        = wp_q + AW'(1);
    end
    if (pop) rp_d = rp_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end

    status          = '0;
    status[1:0]     = mode_q;
    status[2]       = count_q != '0;
    status[3]       = count_q == CW'(FIFO_DEPTH);
    status[4]       = a_pend_q;
    status[5]       = ovf_q;
    status[6]       = unf_q;
    status[7]       = nan_q;
    status[8]       = drp_q;
    status[9 +: CW] = count_q;

    dout_d = dout_q;
    if (rstb) begin
      if (flush)                dout_d = '0;
      else if (dataORstatus)    dout_d = status;
      else if (count_q != '0)   dout_d = mem_q[rp_q];
      else                      dout_d = '0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      mode_q   <= M_MUL;
      prev_w_q <= 1'b0;
      prev_r_q <= 1'b0;
      a_pend_q <= 1'b0;
      a_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      nan_q    <= 1'b0;
      drp_q    <= 1'b0;
      pv_q     <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      prev_w_q <= prev_w_d;
      prev_r_q <= prev_r_d;
      a_pend_q <= a_pend_d;
      a_q      <= a_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      nan_q    <= nan_d;
      drp_q    <= drp_d;
      pv_q     <= pv_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge sysclk) begin
    mem_q <= mem_d;
    pr_q  <= pr_d;
  end

endmodule
